jk_driver: RTL

JK_DRIVER -- requirements
Module: jk_driver

---
 rtl/jk_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/jk_driver.sv
// Drives a JK flop toward a requested q value and checks the result two edges later.
// Optional macro JK_DRIVER_TOGGLE_EN: drive required changes as toggle (j=1,k=1) instead of set/reset.
module jk_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             target;
    logic             target_nxt;
    logic             j_nxt;
    logic             k_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            target  <= 1'b0;
            j       <= 1'b0;
            k       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            target  <= target_nxt;
            j       <= j_nxt;
            k       <= k_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            err_cnt <= cnt_nxt;
        end
    end

    assign tgt_ready = (state == IDLE);

    // j/k are only ever nonzero for the single cycle following an accept.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        j_nxt      = 1'b0;
        k_nxt      = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        cnt_nxt    = err_cnt;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    target_nxt = tgt_bit;
                    state_nxt  = DRIVE;
                    if (q_fb != tgt_bit) begin
`ifdef JK_DRIVER_TOGGLE_EN
                        j_nxt = 1'b1;
                        k_nxt = 1'b1;
`else
                        j_nxt = tgt_bit;
                        k_nxt = ~tgt_bit;
`endif
                    end
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                err_nxt   = (q_fb != target);
                if (err_nxt && (err_cnt != CNT_MAX)) begin
                    cnt_nxt = err_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
